// File: rtl/cla_pkg.sv
// cla_pkg: shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;
    localparam int GROUP_W = 4;
    typedef logic [GROUP_W-1:0] group_t;
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;
    function automatic int group_count(input int width);
        return width / GROUP_W;
    endfunction
endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group with group propagate/generate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       gp,
    output logic       gg,
    output logic       co
);
    group_t p, g, c;
    assign p = a ^ b;
    assign g = a & b;
    always_comb begin
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    end
    assign gp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign co = gg | (gp & ci);
    assign s  = p ^ c;
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready stalling.
// Defining CLA_OVERFLOW_EN adds the registered signed-overflow output ovf.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int G   = group_count(WIDTH);
    localparam int GPS = G / STAGES;
    localparam int SW  = GPS * GROUP_W;

    if (WIDTH % GROUP_W != 0 || STAGES < 1 || STAGES > G || G % STAGES != 0) begin : g_bad_param
        $error("cla_pipe_adder: illegal WIDTH/STAGES combination");
    end

    logic             v_q [STAGES+1];
    logic             c_q [STAGES+1];
    logic [WIDTH-1:0] x_q [STAGES];
    logic [WIDTH-1:0] y_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             sc_d [STAGES];
    logic [WIDTH-1:0] sum_w;
    logic             co_w [G];
    pg_t              pg_w [G];
    logic             advance;

    // each group reads the operand copy held by the slice that resolves it
    for (genvar g = 0; g < G; g++) begin : g_grp
        localparam int K = g / GPS;
        logic ci;
        if (g % GPS == 0) begin : g_first
            assign ci = c_q[K];
        end else begin : g_next
            assign ci = co_w[g-1];
        end
        cla_group4 u_grp (
            .a  (x_q[K][g*GROUP_W +: GROUP_W]),
            .b  (y_q[K][g*GROUP_W +: GROUP_W]),
            .ci (ci),
            .s  (sum_w[g*GROUP_W +: GROUP_W]),
            .gp (pg_w[g].p),
            .gg (pg_w[g].g),
            .co (co_w[g])
        );
    end

    // slice carry-out comes from group P/G so it does not wait on the group sums
    always_comb begin
        s_d[0] = '0;
        for (int k = 1; k < STAGES; k++) s_d[k] = s_q[k-1];
        for (int k = 0; k < STAGES; k++) begin
            s_d[k][k*SW +: SW] = sum_w[k*SW +: SW];
            sc_d[k] = c_q[k];
            for (int j = 0; j < GPS; j++) sc_d[k] = pg_w[k*GPS+j].g | (pg_w[k*GPS+j].p & sc_d[k]);
        end
    end

    assign advance   = !v_q[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES];
    assign z         = s_q[STAGES-1];
    assign cout      = c_q[STAGES];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int k = 0; k <= STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            v_q[0] <= in_valid;
            x_q[0] <= x;
            y_q[0] <= sub ? ~y : y;
            c_q[0] <= sub | cin;
            for (int k = 0; k < STAGES; k++) begin
                v_q[k+1] <= v_q[k];
                c_q[k+1] <= sc_d[k];
                s_q[k]   <= s_d[k];
            end
            for (int k = 1; k < STAGES; k++) begin
                x_q[k] <= x_q[k-1];
                y_q[k] <= y_q[k-1];
            end
        end
    end

`ifdef CLA_OVERFLOW_EN
    logic ovf_q;
    logic msb_c;
    // carry into the MSB is recovered from the MSB sum bit and its operand bits
    assign msb_c = x_q[STAGES-1][WIDTH-1] ^ y_q[STAGES-1][WIDTH-1] ^ sum_w[WIDTH-1];
    always_ff @(posedge clk or negedge res) begin
        if (!res) ovf_q <= 1'b0;
        else if (advance) ovf_q <= msb_c ^ sc_d[STAGES-1];
    end
    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed bench for cla_pipe_adder (WIDTH=16, STAGES=2, latency 3).
module tb_cla_pipe_adder;
    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] z;
    logic        cout;
`ifdef CLA_OVERFLOW_EN
    logic        ovf;
`endif
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16), .STAGES(2)) dut (
        .clk       (clk),
        .res       (res),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .cout      (cout)
`ifdef CLA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        in_valid = 1'b1;
        x = a;
        y = b;
        cin = c;
        sub = s;
    endtask

    task automatic run3(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s,
                        input logic [15:0] ez, input logic ec, input logic eo);
        op(a, b, c, s);
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, " early"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " z"}, 32'(z), 32'(ez));
        chk({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef CLA_OVERFLOW_EN
        chk({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("%s: overflow expectation undefined", tag);
`endif
    endtask

    initial begin
        repeat (3) tick();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset z", 32'(z), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        res = 1'b1;
        tick();

        run3("add", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        tick();
        chk("add single pulse", 32'(out_valid), 32'd0);
        run3("ripple ffff+0+1", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run3("ripple ffff+ffff+1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run3("slice carry", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        run3("sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run3("sub cin ignored", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run3("sub 7-5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run3("sub 8000-1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run3("add 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        tick();
        chk("drain", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        op(16'd1, 16'd2, 1'b0, 1'b0);
        tick();
        op(16'd10, 16'd20, 1'b0, 1'b0);
        tick();
        op(16'd100, 16'd200, 1'b0, 1'b0);
        tick();
        chk("bp full valid", 32'(out_valid), 32'd1);
        chk("bp first z", 32'(z), 32'h3);
        op(16'hFFFF, 16'd2, 1'b0, 1'b0);
        chk("bp in_ready low", 32'(in_ready), 32'd0);
        tick();
        chk("bp hold z", 32'(z), 32'h3);
        chk("bp hold in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bp hold2 z", 32'(z), 32'h3);
        chk("bp hold2 valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp in_ready high", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp second z", 32'(z), 32'h1E);
        chk("bp second valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp third z", 32'(z), 32'h12C);
        tick();
        chk("bp fourth z", 32'(z), 32'h0001);
        chk("bp fourth cout", 32'(cout), 32'd1);
        chk("bp fourth valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp empty", 32'(out_valid), 32'd0);

        op(16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        res = 1'b0;
        #1;
        chk("flush valid", 32'(out_valid), 32'd0);
        chk("flush z", 32'(z), 32'd0);
        tick();
        chk("flush hold valid", 32'(out_valid), 32'd0);
        res = 1'b1;
        tick();
        chk("flush post1 valid", 32'(out_valid), 32'd0);
        tick();
        chk("flush post2 valid", 32'(out_valid), 32'd0);
        run3("after flush", 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
